vie_sram_axi_bridge: RTL and testbench

Converts the CPU core's two sram-like request ports (instruction fetch, data load/store) into a single AXI master port. It sits directly downstream of the CPU core's `inst_sram_*` and `data_sram_*` interfaces and drives the SoC AXI interconnect. At most one read and one write transaction are outstanding at any time.

---
 rtl/vie_sram_axi_bridge_if.sv | 68 ++++++
 rtl/vie_sram_axi_bridge.sv | 184 ++++++++++++++++++
 tb/tb_vie_sram_axi_bridge.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vie_sram_axi_bridge_if.sv
// Signal bundle between the CPU sram-like ports and the AXI master side of the bridge.
// The master modport is the bridge's view; slave is the view of the core plus interconnect.
interface vie_sram_axi_bridge_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output araddr, arsize, arvalid,
    input  arready, rdata, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  araddr, arsize, arvalid,
    output arready, rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready, bvalid,
    input  bready
  );
endinterface

// File: rtl/vie_sram_axi_bridge.sv
// Bridges the CPU fetch and data sram-like ports onto one AXI master with
// at most one read and one write in flight; all AXI outputs come from registers.
module vie_sram_axi_bridge (
  input  logic                  clk,
  input  logic                  resetn,
  vie_sram_axi_bridge_if.master bus
);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_B} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        owner_q, owner_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic r_idle, w_idle, load_req, store_req;
  logic load_acc, store_acc, inst_acc;
  logic aw_done, w_done;

  // A store must not overtake a data load still in flight, or data_ok order breaks.
  always_comb begin
    r_idle    = (r_state_q == R_IDLE);
    w_idle    = (w_state_q == W_IDLE);
    load_req  = bus.data_req & ~bus.data_wr;
    store_req = bus.data_req & bus.data_wr;
    load_acc  = load_req & r_idle & w_idle;
    store_acc = store_req & w_idle & ~(~r_idle & owner_q);
    inst_acc  = bus.inst_req & r_idle & ~load_req;
  end

  always_comb begin
    r_state_d = r_state_q;
    owner_d   = owner_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    arsize_d  = arsize_q;
    case (r_state_q)
      R_IDLE: begin
        if (load_acc) begin
          r_state_d = R_AR;
          owner_d   = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = bus.data_addr;
          arsize_d  = {1'b0, bus.data_size};
        end else if (inst_acc) begin
          r_state_d = R_AR;
          owner_d   = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = bus.inst_addr;
          arsize_d  = 3'd2;
        end
      end
      R_AR: begin
        if (bus.arready) begin
          r_state_d = R_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      R_R: begin
        if (bus.rvalid) begin
          r_state_d = R_IDLE;
          rready_d  = 1'b0;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  // Each channel counts as done once its valid has dropped or is handshaking now.
  always_comb begin
    aw_done   = ~awvalid_q | bus.awready;
    w_done    = ~wvalid_q | bus.wready;
    w_state_d = w_state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (store_acc) begin
          w_state_d = W_SEND;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = bus.data_addr;
          awsize_d  = {1'b0, bus.data_size};
          wdata_d   = bus.data_wdata;
          wstrb_d   = bus.data_wstrb;
        end
      end
      W_SEND: begin
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          w_state_d = W_B;
          bready_d  = 1'b1;
        end
      end
      W_B: begin
        if (bus.bvalid) begin
          w_state_d = W_IDLE;
          bready_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      owner_q   <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      w_state_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      owner_q   <= owner_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      arsize_q  <= arsize_d;
      w_state_q <= w_state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign bus.inst_addr_ok = inst_acc;
  assign bus.data_addr_ok = load_acc | store_acc;
  assign bus.inst_data_ok = rready_q & bus.rvalid & ~owner_q;
  assign bus.data_data_ok = (rready_q & bus.rvalid & owner_q) | (bready_q & bus.bvalid);
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;

  assign bus.araddr  = araddr_q;
  assign bus.arsize  = arsize_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = awaddr_q;
  assign bus.awsize  = awsize_q;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;
endmodule

// File: tb/tb_vie_sram_axi_bridge.sv
// Directed scenarios then random traffic, each cycle compared against a
// transaction-level model of outstanding read/write requests.
module tb_vie_sram_axi_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vie_sram_axi_bridge_if bus();

  vie_sram_axi_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: at most one outstanding read and one outstanding write.
  bit          rd_v, rd_a, rd_own;
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  bit          wr_v, wr_a, wr_d;
  logic [31:0] wr_addr, wr_data;
  logic [2:0]  wr_size;
  logic [3:0]  wr_strb;

  // Observed activity, cleared by directed steps as needed.
  int          n_iok, n_dok, n_arv, n_awv, n_wv;
  logic        o_iaok, o_daok;
  logic [31:0] o_araddr, last_irdata;
  logic [2:0]  o_arsize;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rd_v = 0; rd_a = 0; rd_own = 0;
    wr_v = 0; wr_a = 0; wr_d = 0;
  endtask

  task automatic clear_counts();
    n_iok = 0; n_dok = 0; n_arv = 0; n_awv = 0; n_wv = 0;
  endtask

  task automatic idle();
    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2;
    bus.data_wstrb = '0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.arready = 0; bus.rdata = '0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic step();
    bit e_ar, e_r, e_aw, e_w, e_b, ld, st, e_ld, e_st, e_if, e_iok, e_dok;
    #1;
    e_ar = rd_v && !rd_a;
    e_r  = rd_v && rd_a;
    e_aw = wr_v && !wr_a;
    e_w  = wr_v && !wr_d;
    e_b  = wr_v && wr_a && wr_d;
    ld   = bus.data_req && !bus.data_wr;
    st   = bus.data_req && bus.data_wr;
    e_ld = ld && !rd_v && !wr_v;
    e_st = st && !wr_v && !(rd_v && rd_own);
    e_if = bus.inst_req && !rd_v && !ld;
    e_iok = e_r && bus.rvalid && !rd_own;
    e_dok = (e_r && bus.rvalid && rd_own) || (e_b && bus.bvalid);

    chk("inst_addr_ok", bus.inst_addr_ok, e_if);
    chk("data_addr_ok", bus.data_addr_ok, e_ld || e_st);
    chk("arvalid", bus.arvalid, e_ar);
    chk("rready", bus.rready, e_r);
    chk("awvalid", bus.awvalid, e_aw);
    chk("wvalid", bus.wvalid, e_w);
    chk("bready", bus.bready, e_b);
    chk("inst_data_ok", bus.inst_data_ok, e_iok);
    chk("data_data_ok", bus.data_data_ok, e_dok);
    if (e_ar) begin
      chk("araddr", bus.araddr, rd_addr);
      chk("arsize", bus.arsize, rd_size);
    end
    if (e_aw) begin
      chk("awaddr", bus.awaddr, wr_addr);
      chk("awsize", bus.awsize, wr_size);
    end
    if (e_w) begin
      chk("wdata", bus.wdata, wr_data);
      chk("wstrb", bus.wstrb, wr_strb);
    end
    if (e_iok) chk("inst_rdata", bus.inst_rdata, bus.rdata);
    if (e_r && bus.rvalid && rd_own) chk("data_rdata", bus.data_rdata, bus.rdata);

    o_iaok = bus.inst_addr_ok;
    o_daok = bus.data_addr_ok;
    o_araddr = bus.araddr;
    o_arsize = bus.arsize;
    if (bus.inst_data_ok === 1'b1) begin n_iok++; last_irdata = bus.inst_rdata; end
    if (bus.data_data_ok === 1'b1) n_dok++;
    if (bus.arvalid === 1'b1) n_arv++;
    if (bus.awvalid === 1'b1) n_awv++;
    if (bus.wvalid === 1'b1) n_wv++;

    if (e_r && bus.rvalid) rd_v = 0;
    if (e_ar && bus.arready) rd_a = 1;
    if (e_aw && bus.awready) wr_a = 1;
    if (e_w && bus.wready) wr_d = 1;
    if (e_b && bus.bvalid) wr_v = 0;
    if (e_ld) begin
      rd_v = 1; rd_a = 0; rd_own = 1;
      rd_addr = bus.data_addr; rd_size = {1'b0, bus.data_size};
    end else if (e_if) begin
      rd_v = 1; rd_a = 0; rd_own = 0;
      rd_addr = bus.inst_addr; rd_size = 3'd2;
    end
    if (e_st) begin
      wr_v = 1; wr_a = 0; wr_d = 0;
      wr_addr = bus.data_addr; wr_size = {1'b0, bus.data_size};
      wr_data = bus.data_wdata; wr_strb = bus.data_wstrb;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    clear_counts();
    last_irdata = '0;

    // Reset state
    @(negedge clk);
    bus.inst_req = 1; bus.data_req = 1;
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_wstrb", bus.wstrb, 0);
    idle();
    @(negedge clk);
    resetn = 1;

    // Fetch
    clear_counts();
    bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0000;
    step();
    chk("fetch_accept", o_iaok, 1);
    bus.inst_req = 0; bus.arready = 1;
    step();
    chk("fetch_araddr", o_araddr, 32'hBFC0_0000);
    chk("fetch_arsize", o_arsize, 3'd2);
    bus.arready = 0;
    step();
    bus.rvalid = 1; bus.rdata = 32'h3C1D_0000;
    step();
    bus.rvalid = 0;
    step();
    chk("fetch_pulses", n_iok, 1);
    chk("fetch_rdata", last_irdata, 32'h3C1D_0000);

    // Byte store, address channel delayed
    clear_counts();
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2'd0;
    bus.data_addr = 32'h8000_0003; bus.data_wstrb = 4'b1000; bus.data_wdata = 32'hAB00_0000;
    step();
    chk("store_accept", o_daok, 1);
    bus.data_req = 0; bus.wready = 1; bus.awready = 0;
    step();
    step();
    bus.awready = 1;
    step();
    bus.awready = 0; bus.wready = 0;
    step();
    bus.bvalid = 1;
    step();
    bus.bvalid = 0;
    step();
    chk("store_awvalid_cycles", n_awv, 3);
    chk("store_wvalid_cycles", n_wv, 1);
    chk("store_pulses", n_dok, 1);

    // Same-cycle fetch and load
    idle(); clear_counts();
    bus.inst_req = 1; bus.inst_addr = 32'h0000_0100;
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h0000_1000; bus.data_size = 2'd2;
    step();
    chk("same_cycle_daok", o_daok, 1);
    chk("same_cycle_iaok", o_iaok, 0);
    bus.data_req = 0; bus.arready = 1;
    step();
    chk("load_araddr", o_araddr, 32'h0000_1000);
    chk("load_wait_iaok", o_iaok, 0);
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h5555_AAAA;
    step();
    chk("load_dok_iaok", o_iaok, 0);
    bus.rvalid = 0;
    step();
    chk("fetch_after_load", o_iaok, 1);
    bus.inst_req = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h1234_0001;
    step();
    bus.rvalid = 0;
    step();
    chk("same_cycle_iok", n_iok, 1);
    chk("same_cycle_dok", n_dok, 1);

    // Store outstanding blocks a load; a fetch overlaps it
    idle(); clear_counts();
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 2'd2;
    bus.data_addr = 32'h0000_2000; bus.data_wstrb = 4'hF; bus.data_wdata = 32'hDEAD_BEEF;
    step();
    bus.data_req = 0; bus.awready = 1; bus.wready = 1;
    bus.inst_req = 1; bus.inst_addr = 32'h0000_0200;
    step();
    chk("overlap_fetch_accept", o_iaok, 1);
    bus.inst_req = 0; bus.awready = 0; bus.wready = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0BAD_F00D;
    step();
    chk("overlap_fetch_done", n_iok, 1);
    bus.rvalid = 0;
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_blocked", o_daok, 0);
    end
    bus.bvalid = 1;
    step();
    chk("load_blocked_bvalid", o_daok, 0);
    chk("store_done", n_dok, 1);
    bus.bvalid = 0;
    step();
    chk("load_after_store", o_daok, 1);
    bus.data_req = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h7777_0000;
    step();
    bus.rvalid = 0;
    step();
    chk("load_after_store_dok", n_dok, 2);

    // Reset while in the read-data phase
    idle(); clear_counts();
    bus.inst_req = 1; bus.inst_addr = 32'h0000_0040;
    step();
    bus.inst_req = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'hCAFE_0000;
    #1;
    chk("pre_reset_rready", bus.rready, 1);
    chk("pre_reset_iok", bus.inst_data_ok, 1);
    #1;
    resetn = 0;
    #1;
    chk("mid_reset_rready", bus.rready, 0);
    chk("mid_reset_arvalid", bus.arvalid, 0);
    chk("mid_reset_iok", bus.inst_data_ok, 0);
    chk("mid_reset_dok", bus.data_data_ok, 0);
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1;
    clear_counts();
    bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0004;
    step();
    bus.inst_req = 0; bus.arready = 1;
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h2402_0001;
    step();
    bus.rvalid = 0;
    step();
    chk("post_reset_fetch", n_iok, 1);
    chk("post_reset_rdata", last_irdata, 32'h2402_0001);

    // Random traffic
    clear_counts();
    for (int c = 0; c < 3000; c++) begin
      bus.inst_req   = ($urandom_range(0, 2) != 0);
      bus.inst_addr  = $urandom & 32'hFFFF_FFFC;
      bus.data_req   = ($urandom_range(0, 1) != 0);
      bus.data_wr    = ($urandom_range(0, 1) != 0);
      bus.data_size  = 2'($urandom_range(0, 2));
      bus.data_wstrb = 4'($urandom);
      bus.data_addr  = $urandom;
      bus.data_wdata = $urandom;
      bus.arready    = ($urandom_range(0, 1) != 0);
      bus.awready    = ($urandom_range(0, 1) != 0);
      bus.wready     = ($urandom_range(0, 1) != 0);
      bus.rdata      = $urandom;
      bus.rvalid     = (rd_v && rd_a) ? ($urandom_range(0, 1) != 0) : 1'b0;
      bus.bvalid     = (wr_v && wr_a && wr_d) ? ($urandom_range(0, 1) != 0) : 1'b0;
      step();
    end
    chk("random_inst_progress", (n_iok > 0), 1);
    chk("random_data_progress", (n_dok > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
